// File: rtl/freq_meter.sv
// freq_meter: rising-crossing detector with hysteresis feeding a gated edge counter
// (frequency) and an inter-crossing sample counter (period). All outputs registered.
//
// state   | meaning
// ST_INIT | no valid sample seen since reset
// ST_LOW  | signal below band; waiting for sample >= hi_th
// ST_HIGH | signal above band; waiting for sample <= lo_th
module freq_meter #(
  parameter int DATA_WIDTH  = 12,
  parameter int GATE_CYCLES = 65_000_000,
  parameter int HYST        = 32,
  parameter int OUT_WIDTH   = 20,
  parameter int PER_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] level,
  output logic [OUT_WIDTH-1:0]  freq,
  output logic                  freq_valid,
  output logic                  overflow,
  output logic [PER_WIDTH-1:0]  period_samples,
  output logic                  period_valid
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]     GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [DATA_WIDTH:0]   HYST_X    = (DATA_WIDTH+1)'(HYST);
  localparam logic [OUT_WIDTH-1:0]  EDGE_MAX  = '1;
  localparam logic [PER_WIDTH-1:0]  PER_MAX   = '1;

  typedef enum logic [1:0] {ST_INIT, ST_LOW, ST_HIGH} state_t;

  state_t                state_q, state_d;
  logic [GATE_W-1:0]     gate_q, gate_d;
  logic [OUT_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
  logic                  sticky_q, sticky_d;
  logic [OUT_WIDTH-1:0]  freq_q, freq_d;
  logic                  freq_valid_q, freq_valid_d;
  logic                  overflow_q, overflow_d;
  logic [PER_WIDTH-1:0]  per_cnt_q, per_cnt_d;
  logic                  armed_q, armed_d;
  logic [PER_WIDTH-1:0]  period_q, period_d;
  logic                  period_valid_q, period_valid_d;

  logic [DATA_WIDTH:0]   hi_sum, lo_diff;
  logic [DATA_WIDTH-1:0] hi_th, lo_th;
  logic                  rise;
  logic                  gate_end;
  logic                  edge_sat;
  logic [OUT_WIDTH-1:0]  edge_next;
  logic [PER_WIDTH-1:0]  per_inc;

  // Extra MSB catches carry/borrow so the band clamps to the code range.
  always_comb begin
    hi_sum  = {1'b0, level} + HYST_X;
    lo_diff = {1'b0, level} - HYST_X;
    hi_th   = hi_sum[DATA_WIDTH]  ? '1 : hi_sum[DATA_WIDTH-1:0];
    lo_th   = lo_diff[DATA_WIDTH] ? '0 : lo_diff[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    rise    = 1'b0;
    if (sample_valid) begin
      case (state_q)
        ST_INIT: state_d = (sample >= level) ? ST_HIGH : ST_LOW;
        ST_LOW: begin
          if (sample >= hi_th) begin
            state_d = ST_HIGH;
            rise    = 1'b1;
          end
        end
        ST_HIGH: begin
          if (sample <= lo_th) state_d = ST_LOW;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Gate timer counts down; terminal count 0 is the last cycle of the gate.
  always_comb begin
    gate_end = (gate_q == '0);
    gate_d   = gate_end ? GATE_LAST : gate_q - 1'b1;
  end

  always_comb begin
    edge_sat     = rise && (edge_cnt_q == EDGE_MAX);
    edge_next    = (rise && !edge_sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    freq_d       = freq_q;
    overflow_d   = overflow_q;
    freq_valid_d = 1'b0;
    edge_cnt_d   = edge_next;
    sticky_d     = sticky_q | edge_sat;
    if (gate_end) begin
      freq_d       = edge_next;
      overflow_d   = sticky_q | edge_sat;
      freq_valid_d = 1'b1;
      edge_cnt_d   = '0;
      sticky_d     = 1'b0;
    end
  end

  // First rise after reset only arms; later rises report samples since the previous one.
  always_comb begin
    per_inc        = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
    per_cnt_d      = per_cnt_q;
    armed_d        = armed_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    if (sample_valid) per_cnt_d = per_inc;
    if (rise) begin
      if (armed_q) begin
        period_d       = per_inc;
        period_valid_d = 1'b1;
      end
      armed_d   = 1'b1;
      per_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_INIT;
      gate_q         <= GATE_LAST;
      edge_cnt_q     <= '0;
      sticky_q       <= 1'b0;
      freq_q         <= '0;
      freq_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      per_cnt_q      <= '0;
      armed_q        <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_q         <= gate_d;
      edge_cnt_q     <= edge_cnt_d;
      sticky_q       <= sticky_d;
      freq_q         <= freq_d;
      freq_valid_q   <= freq_valid_d;
      overflow_q     <= overflow_d;
      per_cnt_q      <= per_cnt_d;
      armed_q        <= armed_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign freq           = freq_q;
  assign freq_valid     = freq_valid_q;
  assign overflow       = overflow_q;
  assign period_samples = period_q;
  assign period_valid   = period_valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: table of periodic sample patterns checked on a
// steady gate, plus hand sequences for reset, gate-boundary rise and mid-gate reset.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample;
  logic        sample_valid;
  logic [11:0] level;
  logic [3:0]  freq;
  logic        freq_valid;
  logic        overflow;
  logic [15:0] period_samples;
  logic        period_valid;

  freq_meter #(
    .DATA_WIDTH (12),
    .GATE_CYCLES(1000),
    .HYST       (32),
    .OUT_WIDTH  (4),
    .PER_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .level         (level),
    .freq          (freq),
    .freq_valid    (freq_valid),
    .overflow      (overflow),
    .period_samples(period_samples),
    .period_valid  (period_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pattern generator: one sample every 10 clk, n_lo samples of lo_val then n_hi of hi_val.
  logic        drv_en = 1'b0;
  logic [11:0] lo_val = 12'd0;
  logic [11:0] hi_val = 12'd4000;
  int          n_lo = 5;
  int          n_hi = 5;
  int          tick = 0;
  int          idx  = 0;
  int          plen = 10;

  initial begin
    forever begin
      @(negedge clk);
      if (drv_en) begin
        if (tick == 0) begin
          plen = n_lo + n_hi;
          idx  = idx % plen;
          sample       = (idx < n_lo) ? lo_val : hi_val;
          sample_valid = 1'b1;
          idx  = (idx + 1) % plen;
        end else begin
          sample_valid = 1'b0;
        end
        tick = (tick == 9) ? 0 : tick + 1;
      end
    end
  end

  // Event monitor: snapshots are taken in the same slot as the freq_valid pulse.
  int          pv_cnt = 0;
  int          fv_cnt = 0;
  int          pv_snap = 0;
  int          last_per = 0;
  int          fv_freq = 0;
  int          fv_ovf = 0;

  always @(negedge clk) begin
    if (period_valid) begin
      pv_cnt++;
      last_per = period_samples;
    end
    if (freq_valid) begin
      fv_cnt++;
      pv_snap = pv_cnt;
      fv_freq = freq;
      fv_ovf  = overflow;
    end
  end

  task automatic wait_fv();
    int start;
    bit seen;
    start = fv_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (fv_cnt != start) seen = 1'b1;
    end
    if (!seen) chk("fv_timeout", 0, 1);
  endtask

  typedef struct {
    logic [11:0] lvl;
    logic [11:0] lo;
    logic [11:0] hi;
    int          nlo;
    int          nhi;
    int          exp_freq;
    int          exp_ovf;
    int          exp_npv;
    int          exp_per;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int s0;
    bit got_pv;
    bit early_fv;
    bit fv_seen;

    vecs[0] = '{12'd2048, 12'd0,    12'd4000, 5,  5,  10, 0, 10, 10};
    vecs[1] = '{12'd2048, 12'd2030, 12'd2070, 1,  1,  0,  0, 0,  0};
    vecs[2] = '{12'd2048, 12'd2016, 12'd2080, 5,  5,  10, 0, 10, 10};
    vecs[3] = '{12'd2048, 12'd2017, 12'd2079, 5,  5,  0,  0, 0,  0};
    vecs[4] = '{12'd4090, 12'd0,    12'd4095, 5,  5,  10, 0, 10, 10};
    vecs[5] = '{12'd4090, 12'd0,    12'd4094, 5,  5,  0,  0, 0,  0};
    vecs[6] = '{12'd10,   12'd0,    12'd4000, 5,  5,  10, 0, 10, 10};
    vecs[7] = '{12'd10,   12'd1,    12'd4000, 5,  5,  0,  0, 0,  0};
    vecs[8] = '{12'd2048, 12'd0,    12'd4000, 2,  3,  15, 1, 20, 5};
    vecs[9] = '{12'd2048, 12'd0,    12'd4000, 10, 10, 5,  0, 5,  20};

    rst          = 1'b0;
    level        = 12'd2048;
    sample       = 12'd0;
    sample_valid = 1'b0;
    #2;
    chk("rst_freq", freq, 0);
    chk("rst_freq_valid", freq_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_period", period_samples, 0);
    chk("rst_period_valid", period_valid, 0);

    // Gate boundary: one low sample early, one rise in the last gate cycle (999).
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    early_fv = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (k < 1000 && freq_valid) early_fv = 1'b1;
      if (k == 1000) begin
        chk("bnd_fv_at_1000", freq_valid, 1);
        chk("bnd_freq_incl_rise", freq, 1);
        chk("bnd_overflow", overflow, 0);
      end
      @(negedge clk);
      sample_valid = (k == 5 || k == 999);
      sample       = (k == 999) ? 12'd4000 : 12'd0;
    end
    chk("bnd_no_early_fv", early_fv, 0);
    @(posedge clk);
    #1;
    chk("bnd_fv_one_cycle", freq_valid, 0);
    wait_fv();
    chk("bnd_next_gate_freq", fv_freq, 0);
    chk("bnd_no_period", pv_cnt, 0);

    drv_en = 1'b1;
    for (int v = 0; v < 10; v++) begin
      level  = vecs[v].lvl;
      lo_val = vecs[v].lo;
      hi_val = vecs[v].hi;
      n_lo   = vecs[v].nlo;
      n_hi   = vecs[v].nhi;
      wait_fv();
      s0 = pv_snap;
      wait_fv();
      chk($sformatf("v%0d_freq", v), fv_freq, vecs[v].exp_freq);
      chk($sformatf("v%0d_overflow", v), fv_ovf, vecs[v].exp_ovf);
      chk($sformatf("v%0d_period_count", v), pv_snap - s0, vecs[v].exp_npv);
      if (vecs[v].exp_npv > 0)
        chk($sformatf("v%0d_period", v), last_per, vecs[v].exp_per);
    end

    // Mid-gate reset during a running square wave.
    level  = 12'd2048;
    lo_val = 12'd0;
    hi_val = 12'd4000;
    n_lo   = 5;
    n_hi   = 5;
    wait_fv();
    wait_fv();
    chk("mid_pre_freq", freq, 10);
    repeat (500) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_freq", freq, 0);
    chk("mid_rst_freq_valid", freq_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_period", period_samples, 0);
    chk("mid_rst_period_valid", period_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    got_pv  = 1'b0;
    fv_seen = 1'b0;
    for (int k = 1; k <= 1200 && !fv_seen; k++) begin
      @(posedge clk);
      #1;
      if (period_valid && !got_pv) begin
        got_pv = 1'b1;
        chk("mid_first_period", period_samples, 10);
      end
      if (freq_valid) begin
        fv_seen = 1'b1;
        chk("mid_first_fv_cycle", k, 1000);
      end
    end
    chk("mid_fv_seen", fv_seen, 1);
    chk("mid_pv_seen", got_pv, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
